// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM state codes,
// handshake levels and common constants.
package div_seq_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic        RstEnable         = 1'b1;
   localparam logic        DivResultReady    = 1'b1;
   localparam logic        DivResultNotReady = 1'b0;
   localparam logic        DivStart          = 1'b1;
   localparam logic        DivStop           = 1'b0;
   localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage (master) and the divide
// sequencer (slave).
interface div_seq_if #(
   parameter int DATA_W = 32
);

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  stallreq_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, stallreq_o
   );

endinterface

// File: rtl/div_seq_step.sv
// One restoring-divide iteration: shift {rem, dvd} left, conditionally
// subtract the divisor and shift the new quotient bit into dvd.
module div_seq_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] dvd,
   input  logic [DATA_W-1:0] dsr,
   output logic [DATA_W-1:0] rem_nxt,
   output logic [DATA_W-1:0] dvd_nxt
);

   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] diff;
   logic              take;

   // Compare one bit wider so a shifted remainder above 2^DATA_W never aliases.
   assign rem_sh  = {rem, dvd[DATA_W-1]};
   assign take    = (rem_sh >= {1'b0, dsr});
   assign diff    = rem_sh[DATA_W-1:0] - dsr;
   assign rem_nxt = take ? diff : rem_sh[DATA_W-1:0];
   assign dvd_nxt = {dvd[DATA_W-2:0], take};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipeline
// until the {remainder, quotient} pair is ready for the HI/LO write.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic      clk,
   input  logic      rst,
   div_seq_if.slave  bus
);

   div_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     rem_q, rem_d;
   logic [DATA_W-1:0]     dvd_q, dvd_d;
   logic [DATA_W-1:0]     dsr_q, dsr_d;
   logic                  neg1_q, neg1_d;
   logic                  neg2_q, neg2_d;
   logic                  sdiv_q, sdiv_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;
   logic [DATA_W-1:0]     rem_nxt, dvd_nxt;
   logic signed [DATA_W-1:0] op1_s, op2_s;

   function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
      return ~v + DATA_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] abs_w(input logic signed [DATA_W-1:0] v,
                                               input logic is_signed);
      return (is_signed && (v < 0)) ? neg_w(v) : v;
   endfunction

   assign op1_s = bus.opdata1_i;
   assign op2_s = bus.opdata2_i;

   div_seq_step #(.DATA_W(DATA_W)) u_step (
      .rem     (rem_q),
      .dvd     (dvd_q),
      .dsr     (dsr_q),
      .rem_nxt (rem_nxt),
      .dvd_nxt (dvd_nxt)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      sdiv_d   = sdiv_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         DivFree: begin
            ready_d = DivResultNotReady;
            if (bus.start_i == DivStart && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d = DivOn;
                  cnt_d   = '0;
                  rem_d   = '0;
                  dvd_d   = abs_w(op1_s, bus.signed_div_i);
                  dsr_d   = abs_w(op2_s, bus.signed_div_i);
                  neg1_d  = bus.opdata1_i[DATA_W-1];
                  neg2_d  = bus.opdata2_i[DATA_W-1];
                  sdiv_d  = bus.signed_div_i;
               end
            end
         end
         DivByZero: begin
            ready_d = DivResultNotReady;
            if (bus.annul_i) begin
               state_d = DivFree;
            end else begin
               state_d  = DivEnd;
               result_d = '0;
            end
         end
         DivOn: begin
            if (bus.annul_i) begin
               state_d = DivFree;
               ready_d = DivResultNotReady;
            end else if (cnt_q != CNT_W'(DATA_W)) begin
               rem_d = rem_nxt;
               dvd_d = dvd_nxt;
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               // Magnitude result is final; restore signs before exposing it.
               result_d = {(sdiv_q && neg1_q) ? neg_w(rem_q) : rem_q,
                           (sdiv_q && (neg1_q ^ neg2_q)) ? neg_w(dvd_q) : dvd_q};
               state_d  = DivEnd;
               ready_d  = DivResultReady;
            end
         end
         DivEnd: begin
            if (bus.start_i == DivStop || bus.annul_i) begin
               state_d = DivFree;
               ready_d = DivResultNotReady;
            end else begin
               ready_d = DivResultReady;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         sdiv_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         sdiv_q   <= sdiv_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.result_o   = result_q;
   assign bus.ready_o    = ready_q;
   assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q & ~(rst == RstEnable);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by
// zero, overflow wrap, annul and mid-divide reset.
module tb_div_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   div_seq_if #(.DATA_W(32)) bus ();

   div_seq #(.DATA_W(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      #1;
      check_eq({tag, "_stall_req"}, 64'(bus.stallreq_o), 64'd1);
      tick;
      lat = 0;
      // Operands must be ignored once the divide is under way.
      bus.opdata1_i    = 32'h1234_5678;
      bus.opdata2_i    = 32'h0000_0003;
      bus.signed_div_i = ~sgn;
      while (bus.ready_o !== 1'b1 && lat < 60) begin
         if (lat == 5) check_eq({tag, "_stall_mid"}, 64'(bus.stallreq_o), 64'd1);
         tick;
         lat++;
      end
      check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_result"}, bus.result_o, exp_res);
      check_eq({tag, "_stall_done"}, 64'(bus.stallreq_o), 64'd0);
      tick;
      check_eq({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
      check_eq({tag, "_hold_result"}, bus.result_o, exp_res);
      bus.start_i = 1'b0;
      tick;
      check_eq({tag, "_release_ready"}, 64'(bus.ready_o), 64'd0);
      check_eq({tag, "_release_result"}, bus.result_o, exp_res);
   endtask

   initial begin
      int seen;
      rst              = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'h0;
      bus.opdata2_i    = 32'h0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      repeat (2) tick;
      check_eq("rst_ready", 64'(bus.ready_o), 64'd0);
      check_eq("rst_result", bus.result_o, 64'h0);
      bus.start_i = 1'b1;
      #1;
      check_eq("rst_stall_masked", 64'(bus.stallreq_o), 64'd0);
      bus.start_i = 1'b0;
      rst = 1'b0;
      tick;

      run_div("u7_2",      1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 33);
      run_div("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
      run_div("dbz",       1'b0, 32'd5,          32'd0,          64'h0,                 2);
      run_div("s7_-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33);
      run_div("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33);
      run_div("u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33);
      run_div("s-100_-7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 33);
      run_div("u_big_dsr", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 33);

      // Annul at T+10: nothing may be exposed and the old result stays.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      tick;
      repeat (9) tick;
      bus.annul_i = 1'b1;
      #1;
      check_eq("annul_stall", 64'(bus.stallreq_o), 64'd0);
      tick;
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      check_eq("annul_ready", 64'(bus.ready_o), 64'd0);
      check_eq("annul_result_kept", bus.result_o, 64'h80000000_00000000);
      seen = 0;
      repeat (40) begin
         tick;
         if (bus.ready_o === 1'b1) seen++;
      end
      check_eq("annul_never_ready", 64'(seen), 64'd0);
      run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

      // Reset at T+15 with start still held, then a full-latency restart.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd7;
      bus.opdata2_i    = 32'd2;
      bus.start_i      = 1'b1;
      tick;
      repeat (14) tick;
      rst = 1'b1;
      #1;
      check_eq("midrst_stall", 64'(bus.stallreq_o), 64'd0);
      tick;
      check_eq("midrst_result", bus.result_o, 64'h0);
      check_eq("midrst_ready", 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      run_div("rst_restart", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
